// File: rtl/add_accum_pkg.sv
// Shared types and helpers for the multi-lane add/subtract/accumulate unit.
// Pure declarations: no logic, no latency, no flow control.
package add_accum_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'b00,
        MODE_SUB  = 2'b01,
        MODE_ACC  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam int MODE_W = 2;

    // Lowest bit of lane `lane` in a bus packed as lane i at [i*width +: width].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/add_accum_lane.sv
// One lane: WIDTH+1-bit ALU, optional unsigned clamp, accumulator and result registers.
// Latency 1: result registers load on the edge where load_en is high.
// Backpressure is decided upstream; with load_en low every register holds.
module add_accum_lane
    import add_accum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             sat
);

    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] res;
    logic             clamp;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             sat_q, sat_d;

    // Bit WIDTH of raw is the carry for ADD/ACC and the borrow for SUB.
    always_comb begin
        raw = '0;
        case (mode)
            MODE_ADD:  raw = {1'b0, a} + {1'b0, b};
            MODE_SUB:  raw = {1'b0, a} - {1'b0, b};
            MODE_ACC:  raw = {1'b0, acc_q} + {1'b0, a};
            MODE_LOAD: raw = {1'b0, a};
            default:   raw = '0;
        endcase

        res   = raw[WIDTH-1:0];
        clamp = SATURATE && raw[WIDTH];
        if (clamp) begin
            res = (mode == MODE_SUB) ? '0 : '1;
        end
    end

    always_comb begin
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        if (load_en) begin
            sum_d   = res;
            carry_d = raw[WIDTH];
            sat_d   = clamp;
            // The stored accumulator is the clamped value, not the raw sum.
            if (mode == MODE_ACC || mode == MODE_LOAD) begin
                acc_d = res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
    assign sat   = sat_q;

endmodule

// File: rtl/add_accum_unit.sv
// Multi-lane registered add/sub/accumulate unit with valid/ready on both sides.
// Latency 1 cycle; one beat per cycle sustained through a single output register.
// in_ready = !out_valid || out_ready; a stalled output holds and freezes accumulators.
module add_accum_unit
    import add_accum_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LANES    = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MODE_W-1:0]      in_mode,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_sum,
    output logic [LANES-1:0]       out_carry,
    output logic [LANES-1:0]       out_sat
);

    logic  out_valid_q, out_valid_d;
    logic  accept;
    mode_e mode;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign mode     = mode_e'(in_mode);

    // A new beat keeps valid high even while the old one drains.
    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        add_accum_lane #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load_en (accept),
            .mode    (mode),
            .a       (in_a[lane_lsb(i, WIDTH) +: WIDTH]),
            .b       (in_b[lane_lsb(i, WIDTH) +: WIDTH]),
            .sum     (out_sum[lane_lsb(i, WIDTH) +: WIDTH]),
            .carry   (out_carry[i]),
            .sat     (out_sat[i])
        );
    end

endmodule

// File: tb/tb_add_accum_unit.sv
// Directed bench: two instances (saturating and wrapping) share one stimulus stream.
module tb_add_accum_unit;
    import add_accum_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_mode;
    logic [15:0] in_a, in_b;
    logic        out_ready;

    logic        rdy_s, vld_s, rdy_w, vld_w;
    logic [15:0] sum_s, sum_w;
    logic [1:0]  car_s, sat_s, car_w, sat_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_accum_unit #(.WIDTH(8), .LANES(2), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
        .out_valid(vld_s), .out_ready(out_ready),
        .out_sum(sum_s), .out_carry(car_s), .out_sat(sat_s)
    );

    add_accum_unit #(.WIDTH(8), .LANES(2), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w),
        .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
        .out_valid(vld_w), .out_ready(out_ready),
        .out_sum(sum_w), .out_carry(car_w), .out_sat(sat_w)
    );

    typedef struct {
        mode_e       mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] sum_s;
        logic [1:0]  car_s;
        logic [1:0]  sat_s;
        logic [15:0] sum_w;
        logic [1:0]  car_w;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input mode_e m, input logic [15:0] a, input logic [15:0] b);
        in_valid = vld;
        in_mode  = m;
        in_a     = a;
        in_b     = b;
    endtask

    task automatic check_both(input string tag, input logic vld, input logic [15:0] ss,
                              input logic [1:0] cs, input logic [1:0] s_s,
                              input logic [15:0] sw, input logic [1:0] cw);
        check({tag, " vld_s"}, 16'(vld_s), 16'(vld));
        check({tag, " vld_w"}, 16'(vld_w), 16'(vld));
        check({tag, " sum_s"}, sum_s, ss);
        check({tag, " car_s"}, 16'(car_s), 16'(cs));
        check({tag, " sat_s"}, 16'(sat_s), 16'(s_s));
        check({tag, " sum_w"}, sum_w, sw);
        check({tag, " car_w"}, 16'(car_w), 16'(cw));
        check({tag, " sat_w"}, 16'(sat_w), 16'h0);
    endtask

    initial begin
        // Packed lane1:lane0. Rows 5..8 are LOAD 0x10 then ACC 0x05 x3 on lane1.
        vecs[0]  = '{MODE_ADD,  16'h0110, 16'h0220, 16'h0330, 2'b00, 2'b00, 16'h0330, 2'b00};
        vecs[1]  = '{MODE_ADD,  16'hF0F0, 16'h200F, 16'hFFFF, 2'b10, 2'b10, 16'h10FF, 2'b10};
        vecs[2]  = '{MODE_SUB,  16'h0509, 16'h0905, 16'h0004, 2'b10, 2'b10, 16'hFC04, 2'b10};
        vecs[3]  = '{MODE_SUB,  16'h0080, 16'h0080, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b00};
        vecs[4]  = '{MODE_ADD,  16'hFF00, 16'h0100, 16'hFF00, 2'b10, 2'b10, 16'h0000, 2'b10};
        vecs[5]  = '{MODE_LOAD, 16'h10FE, 16'hAAAA, 16'h10FE, 2'b00, 2'b00, 16'h10FE, 2'b00};
        vecs[6]  = '{MODE_ACC,  16'h0505, 16'hAAAA, 16'h15FF, 2'b01, 2'b01, 16'h1503, 2'b01};
        vecs[7]  = '{MODE_ACC,  16'h0500, 16'h5555, 16'h1AFF, 2'b00, 2'b00, 16'h1A03, 2'b00};
        vecs[8]  = '{MODE_ACC,  16'h05FE, 16'h0000, 16'h1FFF, 2'b01, 2'b01, 16'h1F01, 2'b01};
        vecs[9]  = '{MODE_ADD,  16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b00};
        vecs[10] = '{MODE_ACC,  16'h0101, 16'hFFFF, 16'h20FF, 2'b01, 2'b01, 16'h2002, 2'b00};

        // Reset with a beat offered: it must be discarded.
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, MODE_LOAD, 16'hFFFF, 16'hFFFF);
        tick();
        tick();
        check_both("reset", 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b00);
        rst = 1'b0;
        in_valid = 1'b0;
        check("reset in_ready", 16'(rdy_s), 16'h1);
        tick();
        check("idle vld", 16'(vld_s), 16'h0);

        // Back-to-back table, drain and accept every cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b);
            tick();
            check_both($sformatf("vec%0d", i), 1'b1, vecs[i].sum_s, vecs[i].car_s,
                       vecs[i].sat_s, vecs[i].sum_w, vecs[i].car_w);
        end

        // Stall 4 cycles with ACC offered: output and accumulators frozen.
        out_ready = 1'b0;
        drive(1'b1, MODE_ACC, 16'h0101, 16'h0000);
        #1;
        check("stall in_ready", 16'(rdy_s), 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stall%0d in_ready", i), 16'(rdy_s), 16'h0);
            check_both($sformatf("stall%0d", i), 1'b1, 16'h20FF, 2'b01, 2'b01, 16'h2002, 2'b00);
        end
        out_ready = 1'b1;
        #1;
        check("release in_ready", 16'(rdy_s), 16'h1);
        tick();
        check_both("release1", 1'b1, 16'h21FF, 2'b01, 2'b01, 16'h2103, 2'b00);
        tick();
        check_both("release2", 1'b1, 16'h22FF, 2'b01, 2'b01, 16'h2204, 2'b00);
        in_valid = 1'b0;
        tick();
        check("drain vld_s", 16'(vld_s), 16'h0);
        check("drain vld_w", 16'(vld_w), 16'h0);

        // Reset during a stall holding acc = 0x1F.
        drive(1'b1, MODE_LOAD, 16'h1F1F, 16'h0000);
        tick();
        check_both("load1f", 1'b1, 16'h1F1F, 2'b00, 2'b00, 16'h1F1F, 2'b00);
        out_ready = 1'b0;
        drive(1'b1, MODE_ACC, 16'h0101, 16'h0000);
        tick();
        check_both("stall1f", 1'b1, 16'h1F1F, 2'b00, 2'b00, 16'h1F1F, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_both("midrst", 1'b0, 16'h0000, 2'b00, 2'b00, 16'h0000, 2'b00);
        check("midrst in_ready", 16'(rdy_s), 16'h1);
        out_ready = 1'b1;
        tick();
        check_both("postrst acc", 1'b1, 16'h0101, 2'b00, 2'b00, 16'h0101, 2'b00);
        in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
